// File: rtl/fsic_serdes_pkg.sv
// Shared lane map, flow-control bit positions, FSM encoding and word payload for the FSIC serdes RX path.
package fsic_serdes_pkg;

    localparam int unsigned LANE_TDATA   = 0;
    localparam int unsigned TDATA_LANES  = 8;
    localparam int unsigned LANE_TSTRB   = 8;
    localparam int unsigned LANE_TKEEP   = 9;
    localparam int unsigned LANE_TIDUSER = 10;
    localparam int unsigned LANE_FC      = 11;

    localparam int unsigned FC_TREADY = 0;
    localparam int unsigned FC_TVALID = 1;
    localparam int unsigned FC_TLAST  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic [1:0]  tid;
        logic [1:0]  tuser;
        logic        tlast;
    } rx_word_t;

    localparam int unsigned RX_WORD_W = $bits(rx_word_t);

endpackage

// File: rtl/fsic_rx_word_fifo.sv
// Small register FIFO holding decoded AXIS words; full+pop lets a push through on the same cycle.
module fsic_rx_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 45
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [LW-1:0]    level_d;

    always_comb begin
        pop_ok  = pop && (level != '0);
        push_ok = push && ((level != LW'(DEPTH)) || pop_ok);
        drop_c  = push && !push_ok;
        level_d = level + LW'(push_ok) - LW'(pop_ok);
    end

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            level <= level_d;
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fsic_serdes_rx_deser.sv
// FSIC serdes receive deserializer: frame alignment, lane de-interleave and word FIFO.
// Optional dummy-bit lock check enabled by FSIC_RX_LOCK_CHECK_EN.
module fsic_serdes_rx_deser
    import fsic_serdes_pkg::*;
#(
    parameter int unsigned pSERIALIO_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH     = 32,
    parameter int unsigned pCLK_RATIO      = 4,
    parameter int unsigned pRxFIFO_DEPTH   = 4
) (
    input  logic                       ioclk,
    input  logic                       axis_rst_n,
    input  logic                       rxen,
    input  logic [pSERIALIO_WIDTH-1:0] serial_rxd,
    output logic [pDATA_WIDTH-1:0]     is_as_tdata,
    output logic [pDATA_WIDTH/8-1:0]   is_as_tstrb,
    output logic [pDATA_WIDTH/8-1:0]   is_as_tkeep,
    output logic [1:0]                 is_as_tid,
    output logic [1:0]                 is_as_tuser,
    output logic                       is_as_tlast,
    output logic                       is_as_tvalid,
    input  logic                       is_as_tready_in,
    output logic                       is_as_tready_remote,
    output logic                       rx_locked,
    output logic                       fifo_almost_full,
    output logic                       overflow_err,
    output logic                       align_err
);

    localparam int unsigned PH_W    = $clog2(pCLK_RATIO);
    localparam int unsigned LAST_PH = pCLK_RATIO - 1;
    localparam int unsigned LW      = $clog2(pRxFIFO_DEPTH) + 1;

    rx_state_e                  state_q, state_d;
    logic [PH_W-1:0]            phase_q, phase_d;
    logic [pSERIALIO_WIDTH-1:0] ph_q [LAST_PH];
    logic                       cap_en;
    logic                       done;
    rx_word_t                   word_c;
    logic [pCLK_RATIO-1:0]      tu;
    logic [LAST_PH-1:0]         fc;
    rx_word_t                   word_q;
    logic                       push_q;
    rx_word_t                   head;
    logic [LW-1:0]              fifo_level;
    logic                       fifo_drop;
`ifdef FSIC_RX_LOCK_CHECK_EN
    logic                       lock_err;
`endif

    // Alignment FSM: HUNT treats the first FC-lane 1 as phase 0 of a frame
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cap_en  = 1'b0;
        done    = 1'b0;
`ifdef FSIC_RX_LOCK_CHECK_EN
        lock_err = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rxen) state_d = ST_HUNT;
            end
            ST_HUNT: begin
                if (!rxen) begin
                    state_d = ST_IDLE;
                end else if (serial_rxd[LANE_FC]) begin
                    state_d = ST_LOCKED;
                    phase_d = PH_W'(1);
                    cap_en  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!rxen) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    cap_en  = 1'b1;
                    phase_d = (phase_q == PH_W'(LAST_PH)) ? '0 : phase_q + PH_W'(1);
                    if (phase_q == PH_W'(LAST_PH)) begin
`ifdef FSIC_RX_LOCK_CHECK_EN
                        if (serial_rxd[LANE_FC]) begin
                            lock_err = 1'b1;
                            state_d  = ST_HUNT;
                            phase_d  = '0;
                        end else begin
                            done = 1'b1;
                        end
`else
                        done = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Reassemble the frame from the stored phases plus the live last-phase sample
    always_comb begin
        word_c = '0;
        tu     = '0;
        fc     = '0;
        for (int p = 0; p < LAST_PH; p++) begin
            for (int i = 0; i < TDATA_LANES; i++)
                word_c.tdata[i*pCLK_RATIO+p] = ph_q[p][LANE_TDATA+i];
            word_c.tstrb[p] = ph_q[p][LANE_TSTRB];
            word_c.tkeep[p] = ph_q[p][LANE_TKEEP];
            tu[p]           = ph_q[p][LANE_TIDUSER];
            fc[p]           = ph_q[p][LANE_FC];
        end
        for (int i = 0; i < TDATA_LANES; i++)
            word_c.tdata[i*pCLK_RATIO+LAST_PH] = serial_rxd[LANE_TDATA+i];
        word_c.tstrb[LAST_PH] = serial_rxd[LANE_TSTRB];
        word_c.tkeep[LAST_PH] = serial_rxd[LANE_TKEEP];
        tu[LAST_PH]           = serial_rxd[LANE_TIDUSER];
        word_c.tid            = tu[3:2];
        word_c.tuser          = tu[1:0];
        word_c.tlast          = fc[FC_TLAST];
    end

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q             <= ST_IDLE;
            phase_q             <= '0;
            rx_locked           <= 1'b0;
            push_q              <= 1'b0;
            word_q              <= '0;
            is_as_tready_remote <= 1'b0;
            overflow_err        <= 1'b0;
            for (int p = 0; p < LAST_PH; p++) ph_q[p] <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rx_locked <= (state_d == ST_LOCKED);
            for (int p = 0; p < LAST_PH; p++)
                if (cap_en && (phase_q == PH_W'(p))) ph_q[p] <= serial_rxd;
            push_q <= done && fc[FC_TVALID];
            if (done) begin
                word_q              <= word_c;
                is_as_tready_remote <= fc[FC_TREADY];
            end
            if (fifo_drop) overflow_err <= 1'b1;
        end
    end

`ifdef FSIC_RX_LOCK_CHECK_EN
    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n)   align_err <= 1'b0;
        else if (lock_err) align_err <= 1'b1;
    end
`else
    assign align_err = 1'b0;
`endif

    fsic_rx_word_fifo #(
        .DEPTH (pRxFIFO_DEPTH),
        .WIDTH (RX_WORD_W)
    ) u_fifo (
        .clk    (ioclk),
        .rst_n  (axis_rst_n),
        .push   (push_q),
        .pop    (is_as_tvalid && is_as_tready_in),
        .wdata  (word_q),
        .rdata  (head),
        .level  (fifo_level),
        .drop_c (fifo_drop)
    );

    assign is_as_tvalid     = (fifo_level != '0);
    assign fifo_almost_full = (fifo_level >= LW'(pRxFIFO_DEPTH - 1));
    assign is_as_tdata      = pDATA_WIDTH'(head.tdata);
    assign is_as_tstrb      = head.tstrb;
    assign is_as_tkeep      = head.tkeep;
    assign is_as_tid        = head.tid;
    assign is_as_tuser      = head.tuser;
    assign is_as_tlast      = head.tlast;

endmodule

// File: tb/tb_fsic_serdes_rx_deser.sv
// Directed bench for fsic_serdes_rx_deser; frames are serialised here from their field values.
module tb_fsic_serdes_rx_deser;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic [1:0]  id;
        logic [1:0]  us;
        logic        last;
        logic        valid;
        logic        ready;
        logic        dummy;
    } frm_t;

    logic        ioclk;
    logic        axis_rst_n;
    logic        rxen;
    logic [11:0] serial_rxd;
    logic [31:0] is_as_tdata;
    logic [3:0]  is_as_tstrb;
    logic [3:0]  is_as_tkeep;
    logic [1:0]  is_as_tid;
    logic [1:0]  is_as_tuser;
    logic        is_as_tlast;
    logic        is_as_tvalid;
    logic        is_as_tready_in;
    logic        is_as_tready_remote;
    logic        rx_locked;
    logic        fifo_almost_full;
    logic        overflow_err;
    logic        align_err;

    int n_cmp;
    int n_err;

    frm_t fa, fb, fc, fd, fe, fidle;
    frm_t w [5];

    fsic_serdes_rx_deser dut (
        .ioclk               (ioclk),
        .axis_rst_n          (axis_rst_n),
        .rxen                (rxen),
        .serial_rxd          (serial_rxd),
        .is_as_tdata         (is_as_tdata),
        .is_as_tstrb         (is_as_tstrb),
        .is_as_tkeep         (is_as_tkeep),
        .is_as_tid           (is_as_tid),
        .is_as_tuser         (is_as_tuser),
        .is_as_tlast         (is_as_tlast),
        .is_as_tvalid        (is_as_tvalid),
        .is_as_tready_in     (is_as_tready_in),
        .is_as_tready_remote (is_as_tready_remote),
        .rx_locked           (rx_locked),
        .fifo_almost_full    (fifo_almost_full),
        .overflow_err        (overflow_err),
        .align_err           (align_err)
    );

    initial ioclk = 1'b0;
    always #5 ioclk = ~ioclk;

    function automatic logic [11:0] lanes(input frm_t f, input int p);
        logic [11:0] r;
        logic [3:0]  tu;
        logic [3:0]  fcb;
        tu  = {f.id, f.us};
        fcb = {f.dummy, f.last, f.valid, f.ready};
        for (int i = 0; i < 8; i++) r[i] = f.d[i*4+p];
        r[8]  = f.s[p];
        r[9]  = f.k[p];
        r[10] = tu[p];
        r[11] = fcb[p];
        return r;
    endfunction

    function automatic frm_t mk(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                                input logic [1:0] id, input logic [1:0] us, input logic last,
                                input logic valid, input logic ready, input logic dummy);
        frm_t f;
        f.d = d; f.s = s; f.k = k; f.id = id; f.us = us;
        f.last = last; f.valid = valid; f.ready = ready; f.dummy = dummy;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input frm_t f);
        chk({tag, "_valid"}, 64'(is_as_tvalid), 64'(1));
        chk({tag, "_word"},
            64'({is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast}),
            64'({f.d, f.s, f.k, f.id, f.us, f.last}));
    endtask

    task automatic drive(input frm_t f, input int p);
        @(negedge ioclk);
        serial_rxd = lanes(f, p);
    endtask

    task automatic send(input frm_t f);
        for (int p = 0; p < 4; p++) drive(f, p);
    endtask

    task automatic do_reset();
        axis_rst_n = 1'b0; rxen = 1'b0; serial_rxd = '0; is_as_tready_in = 1'b0;
        repeat (2) @(negedge ioclk);
        axis_rst_n = 1'b1;
    endtask

    // rxen high for one cycle of zeros so the FSM is hunting before the first frame
    task automatic start();
        @(negedge ioclk);
        rxen = 1'b1; serial_rxd = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        fa    = mk(32'hA5A5_1234, 4'hF, 4'hF, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        fb    = mk(32'h0F0F_5A5A, 4'h3, 4'hC, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        fc    = mk(32'h7777_0001, 4'h1, 4'h2, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        fd    = mk(32'h8421_FEDC, 4'h6, 4'h9, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        fe    = mk(32'h3C3C_C3C3, 4'hA, 4'h5, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        fidle = mk(32'hDEAD_BEEF, 4'hF, 4'hF, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        w[0]  = mk(32'h1111_0001, 4'h1, 4'hE, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        w[1]  = mk(32'h2222_0002, 4'h2, 4'hD, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        w[2]  = mk(32'h3333_0003, 4'h3, 4'hC, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        w[3]  = mk(32'h4444_0004, 4'h4, 4'hB, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        w[4]  = mk(32'h5555_0005, 4'h5, 4'hA, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);

        // reset values
        axis_rst_n = 1'b0; rxen = 1'b0; serial_rxd = '0; is_as_tready_in = 1'b0;
        repeat (2) @(negedge ioclk);
        chk("rst_tvalid", 64'(is_as_tvalid), 64'(0));
        chk("rst_word", 64'({is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast}), 64'(0));
        chk("rst_tready_remote", 64'(is_as_tready_remote), 64'(0));
        chk("rst_locked", 64'(rx_locked), 64'(0));
        chk("rst_almost_full", 64'(fifo_almost_full), 64'(0));
        chk("rst_overflow", 64'(overflow_err), 64'(0));
        chk("rst_align", 64'(align_err), 64'(0));
        axis_rst_n = 1'b1;

        // lock and decode one full word, then a no-push frame and a tready=0 frame
        start();
        @(negedge ioclk);
        chk("hunt_unlocked", 64'(rx_locked), 64'(0));
        send(fa);
        drive(fidle, 0);
        chk("a_latency_empty", 64'(is_as_tvalid), 64'(0));
        chk("a_locked", 64'(rx_locked), 64'(1));
        drive(fidle, 1);
        chk_word("a", fa);
        chk("a_tready_remote", 64'(is_as_tready_remote), 64'(1));
        drive(fidle, 2);
        drive(fidle, 3);
        drive(fb, 0);
        chk("idle_tready_remote", 64'(is_as_tready_remote), 64'(1));
        is_as_tready_in = 1'b1;
        drive(fb, 1);
        is_as_tready_in = 1'b0;
        chk("idle_not_pushed", 64'(is_as_tvalid), 64'(0));
        drive(fb, 2);
        drive(fb, 3);
        drive(fidle, 0);
        drive(fidle, 1);
        chk_word("b", fb);
        chk("b_tready_remote", 64'(is_as_tready_remote), 64'(0));
        drive(fidle, 2);
        drive(fidle, 3);

        // overflow with depth 4
        do_reset();
        start();
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 4; p++) begin
                drive(w[k], p);
                if (p == 1 && k == 2) chk("ovf_af_level2", 64'(fifo_almost_full), 64'(0));
                if (p == 1 && k == 3) chk("ovf_af_level3", 64'(fifo_almost_full), 64'(1));
                if (p == 1 && k == 4) chk("ovf_not_yet", 64'(overflow_err), 64'(0));
            end
        end
        drive(fidle, 0);
        drive(fidle, 1);
        chk("ovf_set", 64'(overflow_err), 64'(1));
        chk("ovf_af_full", 64'(fifo_almost_full), 64'(1));
        rxen = 1'b0;
        chk_word("ovf_head0", w[0]);
        is_as_tready_in = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge ioclk);
            chk_word("ovf_head", w[k]);
        end
        @(negedge ioclk);
        chk("ovf_drained", 64'(is_as_tvalid), 64'(0));
        chk("ovf_sticky", 64'(overflow_err), 64'(1));
        is_as_tready_in = 1'b0;

        // push and pop together while full
        do_reset();
        start();
        for (int k = 0; k < 5; k++) send(w[k]);
        drive(fidle, 0);
        is_as_tready_in = 1'b1;
        drive(fidle, 1);
        is_as_tready_in = 1'b0;
        chk("pp_no_overflow", 64'(overflow_err), 64'(0));
        chk("pp_af", 64'(fifo_almost_full), 64'(1));
        rxen = 1'b0;
        chk_word("pp_head1", w[1]);
        is_as_tready_in = 1'b1;
        for (int k = 2; k < 5; k++) begin
            @(negedge ioclk);
            chk_word("pp_head", w[k]);
        end
        @(negedge ioclk);
        chk("pp_drained", 64'(is_as_tvalid), 64'(0));
        chk("pp_no_overflow_end", 64'(overflow_err), 64'(0));
        is_as_tready_in = 1'b0;

        // rxen drop at phase 2 discards the partial frame, relock decodes the next
        do_reset();
        start();
        send(fa);
        drive(fidle, 0);
        drive(fidle, 1);
        chk_word("drop_a", fa);
        drive(fidle, 2);
        drive(fidle, 3);
        drive(fc, 0);
        drive(fc, 1);
        drive(fc, 2);
        rxen = 1'b0;
        @(negedge ioclk);
        chk("drop_unlocked", 64'(rx_locked), 64'(0));
        is_as_tready_in = 1'b1;
        @(negedge ioclk);
        is_as_tready_in = 1'b0;
        repeat (3) @(negedge ioclk);
        chk("drop_no_push", 64'(is_as_tvalid), 64'(0));
        start();
        send(fd);
        drive(fidle, 0);
        drive(fidle, 1);
        chk_word("relock_d", fd);
        chk("relock_locked", 64'(rx_locked), 64'(1));
        drive(fidle, 2);
        is_as_tready_in = 1'b1;
        drive(fidle, 3);
        is_as_tready_in = 1'b0;

        // frame with the dummy bit set
        send(fe);
`ifdef FSIC_RX_LOCK_CHECK_EN
        @(negedge ioclk);
        serial_rxd = '0;
        chk("dummy_align_err", 64'(align_err), 64'(1));
        chk("dummy_hunting", 64'(rx_locked), 64'(0));
        @(negedge ioclk);
        chk("dummy_not_pushed", 64'(is_as_tvalid), 64'(0));
        send(fa);
        drive(fidle, 0);
        drive(fidle, 1);
        chk_word("dummy_relock_a", fa);
        chk("dummy_align_sticky", 64'(align_err), 64'(1));
`else
        drive(fidle, 0);
        drive(fidle, 1);
        chk_word("dummy_ignored_e", fe);
        chk("dummy_align_tied", 64'(align_err), 64'(0));
        chk("dummy_still_locked", 64'(rx_locked), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
